axi_rd_ram_port: RTL and testbench



---
 rtl/axi_rd_ram_pkg.sv | 37 +++
 rtl/axi_rd_ram_port_if.sv | 32 +++
 rtl/axi_rd_ram_port_skid_fifo.sv | 56 +++++
 rtl/axi_rd_ram_port.sv | 160 ++++++++++++++++
 tb/tb_axi_rd_ram_port.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_rd_ram_pkg.sv
// Shared types and constants for the AXI read-to-RAM port.
// Defines the burst and state encodings, the response codes and the beat
// record that moves through the output buffer. It also provides a helper
// that decides whether a WRAP length is legal.
package axi_rd_ram_pkg;

  // Default geometry. The beat record below is sized from these values.
  localparam int AXI_WIDTH_P    = 128;
  localparam int AXI_ID_WIDTH_P = 6;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_WIDTH_P-1:0] id;
    logic [1:0]                resp;
    logic                      last;
    logic [AXI_WIDTH_P-1:0]    data;
  } beat_t;

  // WRAP is only honoured for 2, 4, 8 or 16 beats; anything else runs as INCR.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_rd_ram_port_if.sv
// AXI4 read-channel bundle (AR + R) between a read master and the RAM port.
//   slave  modport : used by axi_rd_ram_port (accepts AR, drives R)
//   master modport : used by the requester (drives AR, accepts R)
interface axi_rd_ram_port_if #(
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6
);
  logic [AXI_ID_WIDTH-1:0]   arid;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      arvalid;
  logic                      arready;
  logic [AXI_ID_WIDTH-1:0]   rid;
  logic [AXI_WIDTH-1:0]      rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_ram_port_skid_fifo.sv
// rd_skid_fifo: 2-entry FIFO of read beats that sits in front of the R channel.
//   push/push_data : write one beat (the caller never pushes into a full FIFO)
//   pop            : drop the head (the caller only pops when count != 0)
//   count          : occupancy 0..2
//   head           : oldest beat; all zeros after reset
module rd_skid_fifo
  import axi_rd_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  beat_t      push_data,
  input  logic       pop,
  output logic [1:0] count,
  output beat_t      head
);

  beat_t      mem_q [2];
  beat_t      mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = 2'(count_q + {1'b0, push} - {1'b0, pop});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/axi_rd_ram_port.sv
// AXI4 read slave that splits AR bursts into single-word RAM reads.
//   clk, rst   : clock, synchronous active-high reset
//   s_axi      : AXI read channels (slave side)
//   ram_ren    : read strobe, at most one per cycle
//   ram_addr   : word address of the read
//   ram_rdata  : RAM data, valid the cycle after ram_ren
// The fixed one-cycle RAM latency is absorbed by a 2-entry beat buffer. Reads
// are issued only when the buffer is guaranteed to have room for them.
//
//   state | meaning
//   IDLE  | arready high, waiting for a burst
//   BURST | issuing one RAM read per credited cycle until beats_left hits 0
module axi_rd_ram_port
  import axi_rd_ram_pkg::*;
#(
  parameter int AXI_WIDTH      = AXI_WIDTH_P,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = AXI_ID_WIDTH_P,
  parameter int LSB            = $clog2(AXI_WIDTH) - 3
) (
  input  logic                          clk,
  input  logic                          rst,
  axi_rd_ram_port_if.slave              s_axi,
  output logic                          ram_ren,
  output logic [AXI_ADDR_WIDTH-LSB-1:0] ram_addr,
  input  logic [AXI_WIDTH-1:0]          ram_rdata
);

  localparam int WADDR_W = AXI_ADDR_WIDTH - LSB;

  localparam logic [0:0] IDLE  = S_IDLE;
  localparam logic [0:0] BURST = S_BURST;

  logic [0:0]              state_q, state_d;
  logic [AXI_ID_WIDTH-1:0] id_q, id_d;
  logic [WADDR_W-1:0]      waddr_q, waddr_d;
  logic [7:0]              beats_left_q, beats_left_d;
  logic [7:0]              len_q, len_d;
  burst_e                  burst_q, burst_d;
  logic                    err_q, err_d;

  // Sideband of the read currently inside the RAM.
  logic                    infl_q, infl_d;
  logic [AXI_ID_WIDTH-1:0] infl_id_q, infl_id_d;
  logic                    infl_last_q, infl_last_d;
  logic [1:0]              infl_resp_q, infl_resp_d;

  logic [1:0]         fifo_count;
  beat_t              fifo_head;
  beat_t              push_beat;
  logic               pop;
  logic               credit;
  logic [WADDR_W-1:0] wrap_mask;
  logic [WADDR_W-1:0] waddr_inc;

  assign pop = s_axi.rvalid & s_axi.rready;
  // Entries that will be in the buffer once the in-flight read lands.
  assign credit    = (3'(fifo_count) + 3'(infl_q) - 3'(pop)) < 3'd2;
  assign wrap_mask = WADDR_W'(len_q);
  assign waddr_inc = waddr_q + 1'b1;

  assign s_axi.arready = (state_q == IDLE) && !rst;
  assign ram_ren       = (state_q == BURST) && credit;
  assign ram_addr      = waddr_q;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    waddr_d      = waddr_q;
    beats_left_d = beats_left_q;
    len_d        = len_q;
    burst_d      = burst_q;
    err_d        = err_q;

    if (s_axi.arvalid && s_axi.arready) begin
      state_d      = BURST;
      id_d         = s_axi.arid;
      waddr_d      = WADDR_W'(s_axi.araddr >> LSB);
      beats_left_d = s_axi.arlen;
      len_d        = s_axi.arlen;
      err_d        = (s_axi.arsize != 3'(LSB));
      // Reserved type and illegal WRAP lengths collapse to INCR here so the
      // address step below only has three cases.
      unique case (s_axi.arburst)
        2'b00:   burst_d = BURST_FIXED;
        2'b10:   burst_d = wrap_len_ok(s_axi.arlen) ? BURST_WRAP : BURST_INCR;
        default: burst_d = BURST_INCR;
      endcase
    end

    if (ram_ren) begin
      beats_left_d = beats_left_q - 8'd1;
      unique case (burst_q)
        BURST_FIXED: waddr_d = waddr_q;
        BURST_WRAP:  waddr_d = (waddr_q & ~wrap_mask) | (waddr_inc & wrap_mask);
        default:     waddr_d = waddr_inc;
      endcase
      if (beats_left_q == 8'd0) begin
        state_d = IDLE;
      end
    end

    infl_d      = ram_ren;
    infl_id_d   = id_q;
    infl_last_d = (beats_left_q == 8'd0);
    infl_resp_d = err_q ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      id_q         <= '0;
      waddr_q      <= '0;
      beats_left_q <= 8'd0;
      len_q        <= 8'd0;
      burst_q      <= BURST_FIXED;
      err_q        <= 1'b0;
      infl_q       <= 1'b0;
      infl_id_q    <= '0;
      infl_last_q  <= 1'b0;
      infl_resp_q  <= RESP_OKAY;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      waddr_q      <= waddr_d;
      beats_left_q <= beats_left_d;
      len_q        <= len_d;
      burst_q      <= burst_d;
      err_q        <= err_d;
      infl_q       <= infl_d;
      infl_id_q    <= infl_id_d;
      infl_last_q  <= infl_last_d;
      infl_resp_q  <= infl_resp_d;
    end
  end

  always_comb begin
    push_beat.id   = infl_id_q;
    push_beat.resp = infl_resp_q;
    push_beat.last = infl_last_q;
    push_beat.data = ram_rdata;
  end

  rd_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_q),
    .push_data (push_beat),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign s_axi.rvalid = (fifo_count != 2'd0);
  assign s_axi.rid    = fifo_head.id;
  assign s_axi.rresp  = fifo_head.resp;
  assign s_axi.rlast  = fifo_head.last;
  assign s_axi.rdata  = fifo_head.data;

endmodule

// File: tb/tb_axi_rd_ram_port.sv
// Directed bench for axi_rd_ram_port: a vector table of bursts with rready high,
// plus hand-written sequences for latency, backpressure, reset and address wrap.
// RAM model: word n holds {4{32-bit n}}, returned the cycle after ram_ren.
module tb_axi_rd_ram_port;
  import axi_rd_ram_pkg::*;

  localparam int DW  = 128;
  localparam int AW  = 32;
  localparam int IW  = 6;
  localparam int LSB = 4;
  localparam int WW  = AW - LSB;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_ren;
  logic [WW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  axi_rd_ram_port_if #(.AXI_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) axi_if ();

  axi_rd_ram_port #(.AXI_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axi     (axi_if.slave),
    .ram_ren   (ram_ren),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata)
  );

  function automatic logic [DW-1:0] word(input logic [WW-1:0] n);
    return {4{32'(n)}};
  endfunction

  logic [WW-1:0] ren_q[$];

  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= word(ram_addr);
    if (!rst && ram_ren) ren_q.push_back(ram_addr);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_ar(input logic [AW-1:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [2:0] s, input logic [IW-1:0] id);
    int t;
    @(negedge clk);
    axi_if.araddr  = a;
    axi_if.arlen   = l;
    axi_if.arburst = b;
    axi_if.arsize  = s;
    axi_if.arid    = id;
    axi_if.arvalid = 1'b1;
    t = 0;
    while (!axi_if.arready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ar_accept", DW'(axi_if.arready), DW'(1));
    @(negedge clk);
    axi_if.arvalid = 1'b0;
  endtask

  // Checks the current negedge first; on a beat, returns at the next negedge.
  task automatic get_beat(output logic [IW-1:0] id, output logic [DW-1:0] data,
                          output logic [1:0] resp, output logic last,
                          output bit ok, output int waited);
    int t;
    ok = 1'b0; t = 0;
    id = '0; data = '0; resp = '0; last = 1'b0;
    while (t < 64) begin
      if (axi_if.rvalid && axi_if.rready) begin
        id = axi_if.rid; data = axi_if.rdata; resp = axi_if.rresp; last = axi_if.rlast;
        ok = 1'b1;
      end
      @(negedge clk);
      if (ok) break;
      t++;
    end
    waited = t;
    if (!ok) chk("beat_timeout", DW'(0), DW'(1));
  endtask

  typedef struct {
    logic [AW-1:0]        addr;
    logic [7:0]           len;
    logic [1:0]           burst;
    logic [2:0]           size;
    logic [IW-1:0]        id;
    logic [3:0][WW-1:0]   exp_addr;
    logic [1:0]           exp_resp;
  } vec_t;

  function automatic vec_t mk(input logic [AW-1:0] a, input logic [7:0] l, input logic [1:0] b,
                              input logic [2:0] s, input logic [IW-1:0] id,
                              input int a0, input int a1, input int a2, input int a3,
                              input logic [1:0] r);
    vec_t v;
    v.addr = a; v.len = l; v.burst = b; v.size = s; v.id = id;
    v.exp_addr[0] = WW'(a0); v.exp_addr[1] = WW'(a1);
    v.exp_addr[2] = WW'(a2); v.exp_addr[3] = WW'(a3);
    v.exp_resp = r;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t          vecs[8];
    logic [IW-1:0] bid;
    logic [DW-1:0] bdata, held;
    logic [1:0]    bresp;
    logic          blast;
    bit            ok, seen;
    int            waited, base, cnt;
    logic [WW-1:0] ea;

    vecs[0] = mk(32'h40,  8'd0, 2'b01, 3'd4, 6'h05, 4,  0,  0,  0,  RESP_OKAY);
    vecs[1] = mk(32'h100, 8'd3, 2'b01, 3'd4, 6'h09, 16, 17, 18, 19, RESP_OKAY);
    vecs[2] = mk(32'h120, 8'd3, 2'b10, 3'd4, 6'h2A, 18, 19, 16, 17, RESP_OKAY);
    vecs[3] = mk(32'h200, 8'd2, 2'b00, 3'd4, 6'h03, 32, 32, 32, 0,  RESP_OKAY);
    vecs[4] = mk(32'h300, 8'd1, 2'b01, 3'd2, 6'h07, 48, 49, 0,  0,  RESP_SLVERR);
    vecs[5] = mk(32'h130, 8'd2, 2'b10, 3'd4, 6'h01, 19, 20, 21, 0,  RESP_OKAY);
    vecs[6] = mk(32'h50,  8'd1, 2'b11, 3'd4, 6'h3F, 5,  6,  0,  0,  RESP_OKAY);
    vecs[7] = mk(32'h170, 8'd1, 2'b10, 3'd4, 6'h04, 23, 22, 0,  0,  RESP_OKAY);

    rst = 1'b1;
    axi_if.arvalid = 1'b0; axi_if.araddr = '0; axi_if.arlen = '0;
    axi_if.arsize = '0; axi_if.arburst = '0; axi_if.arid = '0; axi_if.rready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_arready", DW'(axi_if.arready), DW'(0));
    chk("rst_rvalid",  DW'(axi_if.rvalid),  DW'(0));
    chk("rst_ren",     DW'(ram_ren),        DW'(0));
    chk("rst_rdata",   axi_if.rdata,        DW'(0));
    rst = 1'b0;
    #1;
    chk("rst_arready_after", DW'(axi_if.arready), DW'(1));

    // Single-beat latency: ren in cycle 1, rvalid in cycle 3
    axi_if.rready = 1'b1;
    send_ar(32'h40, 8'd0, 2'b01, 3'd4, 6'h12);
    chk("lat_ren_c1",  DW'(ram_ren),  DW'(1));
    chk("lat_addr_c1", DW'(ram_addr), DW'(4));
    @(negedge clk);
    chk("lat_rvalid_c2", DW'(axi_if.rvalid), DW'(0));
    @(negedge clk);
    chk("lat_rvalid_c3", DW'(axi_if.rvalid), DW'(1));
    chk("lat_rdata", axi_if.rdata, word(4));
    chk("lat_rlast", DW'(axi_if.rlast), DW'(1));
    chk("lat_rid",   DW'(axi_if.rid),   DW'(6'h12));
    repeat (2) @(negedge clk);

    // Next AR accepted the cycle after the last ren (4 rens in cycles 1..4)
    send_ar(32'h100, 8'd3, 2'b01, 3'd4, 6'h0A);
    cnt = 0;
    while (!axi_if.arready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("arready_return_cycles", DW'(cnt), DW'(4));
    repeat (6) @(negedge clk);

    // Vector table, rready held high
    for (int v = 0; v < 8; v++) begin
      base = ren_q.size();
      send_ar(vecs[v].addr, vecs[v].len, vecs[v].burst, vecs[v].size, vecs[v].id);
      for (int b = 0; b <= int'(vecs[v].len); b++) begin
        get_beat(bid, bdata, bresp, blast, ok, waited);
        chk($sformatf("v%0d_b%0d_data", v, b), bdata, word(vecs[v].exp_addr[b]));
        chk($sformatf("v%0d_b%0d_id",   v, b), DW'(bid),   DW'(vecs[v].id));
        chk($sformatf("v%0d_b%0d_resp", v, b), DW'(bresp), DW'(vecs[v].exp_resp));
        chk($sformatf("v%0d_b%0d_last", v, b), DW'(blast), DW'(b == int'(vecs[v].len)));
        if (b > 0) chk($sformatf("v%0d_b%0d_gap", v, b), DW'(waited), DW'(0));
      end
      chk($sformatf("v%0d_ren_count", v), DW'(ren_q.size() - base), DW'(int'(vecs[v].len) + 1));
      for (int b = 0; b <= int'(vecs[v].len); b++) begin
        if (base + b < ren_q.size())
          chk($sformatf("v%0d_ren_addr%0d", v, b), DW'(ren_q[base + b]), DW'(vecs[v].exp_addr[b]));
      end
    end

    // Backpressure: 8-beat INCR at word 64, rready low for 10 cycles
    axi_if.rready = 1'b0;
    base = ren_q.size();
    send_ar(32'h400, 8'd7, 2'b01, 3'd4, 6'h11);
    seen = 1'b0; held = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (axi_if.rvalid) begin
        if (!seen) begin
          seen = 1'b1;
          held = axi_if.rdata;
        end else begin
          chk("bp_hold_data", axi_if.rdata, held);
          chk("bp_hold_last", DW'(axi_if.rlast), DW'(0));
        end
      end
    end
    chk("bp_rvalid_seen", DW'(seen), DW'(1));
    chk("bp_first_data", held, word(64));
    chk("bp_ren_before_release", DW'(ren_q.size() - base), DW'(2));
    axi_if.rready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      get_beat(bid, bdata, bresp, blast, ok, waited);
      chk($sformatf("bp_b%0d_data", b), bdata, word(WW'(64 + b)));
      chk($sformatf("bp_b%0d_last", b), DW'(blast), DW'(b == 7));
    end
    chk("bp_ren_total", DW'(ren_q.size() - base), DW'(8));
    repeat (3) @(negedge clk);

    // Reset during beat 3 of 8
    send_ar(32'h600, 8'd7, 2'b01, 3'd4, 6'h15);
    for (int b = 0; b < 2; b++) begin
      get_beat(bid, bdata, bresp, blast, ok, waited);
      chk($sformatf("mr_b%0d_data", b), bdata, word(WW'(96 + b)));
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mr_rvalid_after_rst", DW'(axi_if.rvalid), DW'(0));
    chk("mr_ren_after_rst",    DW'(ram_ren),       DW'(0));
    rst = 1'b0;
    #1;
    chk("mr_arready_after_rst", DW'(axi_if.arready), DW'(1));
    base = ren_q.size();
    send_ar(32'h80, 8'd0, 2'b01, 3'd4, 6'h2C);
    get_beat(bid, bdata, bresp, blast, ok, waited);
    chk("mr_new_data", bdata, word(8));
    chk("mr_new_id",   DW'(bid),   DW'(6'h2C));
    chk("mr_new_last", DW'(blast), DW'(1));
    chk("mr_new_resp", DW'(bresp), DW'(RESP_OKAY));
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (axi_if.rvalid) cnt++;
    end
    chk("mr_no_stale_beats", DW'(cnt), DW'(0));
    chk("mr_ren_count", DW'(ren_q.size() - base), DW'(1));

    // arlen=255 INCR wrapping at the top of the word space
    base = ren_q.size();
    send_ar(32'hFFFF_FF00, 8'd255, 2'b01, 3'd4, 6'h22);
    for (int b = 0; b < 256; b++) begin
      ea = WW'(28'hFFF_FFF0 + b);
      get_beat(bid, bdata, bresp, blast, ok, waited);
      chk($sformatf("wrap_b%0d_data", b), bdata, word(ea));
      chk($sformatf("wrap_b%0d_last", b), DW'(blast), DW'(b == 255));
    end
    chk("wrap_ren_count", DW'(ren_q.size() - base), DW'(256));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
